// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM encodings, requester IDs
// and funct3 access-size codes.
package dmem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Value parked on mem_funct3 whenever no access is in flight.
    localparam logic [2:0] F3_IDLE = 3'b010;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, debug and memory-side signals of dmem_arbiter.
// slave = the arbiter, master = requesters plus the data memory.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [2:0]            core_funct3;
    logic                  core_gnt;
    logic                  core_rvalid;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  core_err;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic [2:0]            dbg_funct3;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_err;

    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [2:0]            mem_funct3;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_funct3,
        output core_gnt, core_rvalid, core_rdata, core_err,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output mem_wr_en, mem_addr, mem_wr_data, mem_funct3,
        input  mem_rd_data
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_funct3,
        input  core_gnt, core_rvalid, core_rdata, core_err,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  mem_wr_en, mem_addr, mem_wr_data, mem_funct3,
        output mem_rd_data
    );

endinterface

// File: rtl/dmem_align_check.sv
// Combinational legality check for a data-memory access: illegal size,
// misalignment for halfword/word, or byte address beyond the memory.
module dmem_align_check
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            funct3_i,
    output logic                  err_o
);

    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_SIZE * 4);

    logic misaligned;
    // Sign/zero-extension bit plays no part in legality.
    logic unused_ext;
    assign unused_ext = funct3_i[2];

    always_comb begin
        misaligned = 1'b0;
        case (funct3_i[1:0])
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addr_i[0];
            SZ_W:    misaligned = (addr_i[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign err_o = misaligned | (addr_i >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between core MEM stage and debug port: grant,
// one ACCESS cycle, one registered RESP cycle. DMEM_ARB_RR_EN selects round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    logic [1:0]            state_q, state_d;
    logic                  lat_we_q;
    logic [ADDR_WIDTH-1:0] lat_addr_q;
    logic [DATA_WIDTH-1:0] lat_wdata_q;
    logic [2:0]            lat_f3_q;
    req_id_e               lat_id_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q;

    logic can_grant, core_wins, grant, acc_err;
    logic in_access, in_resp, core_rvalid, dbg_rvalid;

    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);
    // Grants are combinational, so they are also held off while reset is asserted.
    assign can_grant = rst_n & (state_q == ST_IDLE || state_q == ST_RESP);

`ifdef DMEM_ARB_RR_EN
    req_id_e last_q;
    assign core_wins = bus.core_req & (~bus.dbg_req | (last_q == REQ_DBG));
`else
    assign core_wins = bus.core_req;
`endif

    assign grant        = can_grant & (bus.core_req | bus.dbg_req);
    assign bus.core_gnt = can_grant & core_wins;
    assign bus.dbg_gnt  = can_grant & bus.dbg_req & ~core_wins;

    dmem_align_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_align_check (
        .addr_i   (lat_addr_q),
        .funct3_i (lat_f3_q),
        .err_o    (acc_err)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = grant ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_f3_q    <= 3'b000;
            lat_id_q    <= REQ_CORE;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                lat_id_q    <= core_wins ? REQ_CORE : REQ_DBG;
                lat_we_q    <= core_wins ? bus.core_we     : bus.dbg_we;
                lat_addr_q  <= core_wins ? bus.core_addr   : bus.dbg_addr;
                lat_wdata_q <= core_wins ? bus.core_wdata  : bus.dbg_wdata;
                lat_f3_q    <= core_wins ? bus.core_funct3 : bus.dbg_funct3;
            end
            // Memory returns load data already sized and extended.
            if (in_access) begin
                rsp_data_q <= (lat_we_q | acc_err) ? '0 : bus.mem_rd_data;
                rsp_err_q  <= acc_err;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_DBG;
        end else if (grant) begin
            last_q <= core_wins ? REQ_CORE : REQ_DBG;
        end
    end
`endif

    assign bus.mem_wr_en   = in_access & lat_we_q & ~acc_err;
    assign bus.mem_addr    = in_access ? lat_addr_q  : '0;
    assign bus.mem_wr_data = in_access ? lat_wdata_q : '0;
    assign bus.mem_funct3  = in_access ? lat_f3_q    : F3_IDLE;

    assign core_rvalid     = in_resp & (lat_id_q == REQ_CORE);
    assign dbg_rvalid      = in_resp & (lat_id_q == REQ_DBG);
    assign bus.core_rvalid = core_rvalid;
    assign bus.dbg_rvalid  = dbg_rvalid;
    assign bus.core_rdata  = core_rvalid ? rsp_data_q : '0;
    assign bus.dbg_rdata   = dbg_rvalid  ? rsp_data_q : '0;
    assign bus.core_err    = core_rvalid & rsp_err_q;
    assign bus.dbg_err     = dbg_rvalid  & rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model with a byte-array memory image.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory attached to the arbiter: word array, sized reads, lane writes.
  logic [31:0] tmem [64] = '{default: 32'h0};
  logic [31:0] tm_word, tm_rd;
  logic [7:0]  tm_b;
  logic [15:0] tm_h;

  always_comb begin
    tm_word = tmem[bus.mem_addr[7:2]];
    tm_b    = tm_word[8*bus.mem_addr[1:0] +: 8];
    tm_h    = tm_word[16*bus.mem_addr[1] +: 16];
    case (bus.mem_funct3)
      3'b000:  tm_rd = {{24{tm_b[7]}}, tm_b};
      3'b001:  tm_rd = {{16{tm_h[15]}}, tm_h};
      3'b100:  tm_rd = {24'h0, tm_b};
      3'b101:  tm_rd = {16'h0, tm_h};
      default: tm_rd = tm_word;
    endcase
  end
  assign bus.mem_rd_data = tm_rd;

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      case (bus.mem_funct3[1:0])
        2'b00:   tmem[bus.mem_addr[7:2]][8*bus.mem_addr[1:0] +: 8] <= bus.mem_wr_data[7:0];
        2'b01:   tmem[bus.mem_addr[7:2]][16*bus.mem_addr[1] +: 16] <= bus.mem_wr_data[15:0];
        default: tmem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
      endcase
    end
  end

  typedef struct {
    bit          v;
    bit          id;
    bit          we;
    bit          err;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] rd;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;

  logic [7:0]  ref_mem [256];
  bit          p_req [2];
  bit          p_we [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];
  logic [2:0]  p_f3 [2];
  bit          hold [2];
  bit          rnd_on;
  bit          gnt_last;
  bit          lastw;
  txn_t        s1, s2;
  logic [31:0] obs_rd [2];
  logic [31:0] obs_err [2];
  bit          gseq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] a, input logic [2:0] f);
    int sz;
    sz = 1 << f[1:0];
    if (f[1:0] == 2'b11) return 1'b1;
    if (a >= 32'd256) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
    int n;
    logic [31:0] v;
    n = 1 << f[1:0];
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a[7:0]) + i]) << (8 * i));
    if (n < 4 && !f[2] && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd);
    int n;
    n = 1 << f[1:0];
    for (int i = 0; i < n; i++) ref_mem[int'(a[7:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic set_req(input bit id, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
    p_req[id] = 1'b1;
    p_we[id]  = we;
    p_addr[id] = a;
    p_wd[id]  = wd;
    p_f3[id]  = f3;
  endtask

  task automatic rand_req(input bit id);
    logic [31:0] a;
    int sel;
    sel = $urandom_range(15);
    if (sel == 0)      a = $urandom;
    else if (sel == 1) a = 32'hFC + 32'($urandom_range(7));
    else               a = 32'($urandom_range(255));
    if ($urandom_range(1) == 1) a[1:0] = 2'b00;
    set_req(id, 1'($urandom_range(1)), a, $urandom, 3'($urandom_range(7)));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      if (hold[i] && !p_req[i])
        set_req(1'(i), 1'b0, 32'h40 + 32'(4 * i), 32'h0, 3'b010);
      else if (rnd_on && !p_req[i] && $urandom_range(2) == 0)
        rand_req(1'(i));
      else if (rnd_on && p_req[i] && $urandom_range(19) == 0)
        p_req[i] = 1'b0;
    end
    bus.core_req    = p_req[0];
    bus.core_we     = p_we[0];
    bus.core_addr   = p_addr[0];
    bus.core_wdata  = p_wd[0];
    bus.core_funct3 = p_f3[0];
    bus.dbg_req     = p_req[1];
    bus.dbg_we      = p_we[1];
    bus.dbg_addr    = p_addr[1];
    bus.dbg_wdata   = p_wd[1];
    bus.dbg_funct3  = p_f3[1];
  endtask

  // One clock cycle: entered just after a falling edge, returns at the next one.
  task automatic cycle();
    bit cw, eg_c, eg_d, w;
    logic [31:0] got_rd, got_err;
    drive_inputs();
    #1;
`ifdef DMEM_ARB_RR_EN
    cw = p_req[0] && (!p_req[1] || lastw);
`else
    cw = p_req[0];
`endif
    eg_c = !gnt_last && cw;
    eg_d = !gnt_last && p_req[1] && !cw;
    check("core_gnt", 32'(bus.core_gnt), 32'(eg_c));
    check("dbg_gnt", 32'(bus.dbg_gnt), 32'(eg_d));

    check("mem_wr_en", 32'(bus.mem_wr_en), 32'(s1.v && s1.we && !s1.err));
    if (bus.mem_wr_en) wr_cnt++;
    if (s1.v) begin
      check("mem_addr", bus.mem_addr, s1.addr);
      check("mem_funct3", 32'(bus.mem_funct3), 32'(s1.f3));
      if (s1.we && !s1.err) check("mem_wr_data", bus.mem_wr_data, s1.wd);
    end else begin
      check("mem_addr_idle", bus.mem_addr, 32'h0);
      check("mem_funct3_idle", 32'(bus.mem_funct3), 32'h2);
      check("mem_wr_data_idle", bus.mem_wr_data, 32'h0);
    end

    check("core_rvalid", 32'(bus.core_rvalid), 32'(s2.v && !s2.id));
    check("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(s2.v && s2.id));
    if (s2.v) begin
      got_rd  = s2.id ? bus.dbg_rdata : bus.core_rdata;
      got_err = s2.id ? 32'(bus.dbg_err) : 32'(bus.core_err);
      check(s2.id ? "dbg_rdata" : "core_rdata", got_rd, s2.rd);
      check(s2.id ? "dbg_err" : "core_err", got_err, 32'(s2.err));
      obs_rd[s2.id]  = got_rd;
      obs_err[s2.id] = got_err;
    end

    if (s1.v && !s1.err) begin
      if (s1.we) ref_store(s1.addr, s1.f3, s1.wd);
      else       s1.rd = ref_load(s1.addr, s1.f3);
    end
    s2 = s1;
    s1.v = 1'b0;
    if (eg_c || eg_d) begin
      w       = eg_d;
      s1.v    = 1'b1;
      s1.id   = w;
      s1.we   = p_we[w];
      s1.addr = p_addr[w];
      s1.wd   = p_wd[w];
      s1.f3   = p_f3[w];
      s1.err  = ref_err(p_addr[w], p_f3[w]);
      s1.rd   = 32'h0;
      p_req[w] = 1'b0;
      gseq.push_back(w);
      lastw = w;
    end
    gnt_last = eg_c || eg_d;
    @(negedge clk);
  endtask

  task automatic wait_grant(input bit id);
    int n;
    n = 0;
    while (p_req[id] && n < 50) begin
      cycle();
      n++;
    end
    check("grant_timeout", 32'(p_req[id]), 32'h0);
    p_req[id] = 1'b0;
  endtask

  task automatic issue(input bit id, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    set_req(id, we, a, wd, f3);
    wait_grant(id);
    cycle();
    cycle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((p_req[0] || p_req[1]) && n < 60) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(p_req[0] || p_req[1]), 32'h0);
    repeat (3) cycle();
  endtask

  task automatic model_reset();
    s1.v = 1'b0;
    s2.v = 1'b0;
    gnt_last = 1'b0;
    lastw = 1'b1;
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
  endtask

  initial begin
    int wr_before, n, core_cnt, changes, dbg_idx;
    bit served;
    clk = 1'b0;
    rst_n = 1'b0;
    rnd_on = 1'b0;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
    for (int i = 0; i < 2; i++) set_req(1'(i), 1'b0, 32'h0, 32'h0, 3'b010);
    model_reset();
    drive_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_core_gnt", 32'(bus.core_gnt), 32'h0);
    check("rst_dbg_gnt", 32'(bus.dbg_gnt), 32'h0);
    check("rst_core_rvalid", 32'(bus.core_rvalid), 32'h0);
    check("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    check("rst_core_rdata", bus.core_rdata, 32'h0);
    check("rst_core_err", 32'(bus.core_err), 32'h0);
    check("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_funct3", 32'(bus.mem_funct3), 32'h2);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 3'b010);
    check("lw_0x10", obs_rd[0], 32'hDEADBEEF);
    check("lw_0x10_err", obs_err[0], 32'h0);

    // Byte store and extended loads
    issue(1'b0, 1'b1, 32'h13, 32'h80, 3'b000);
    issue(1'b0, 1'b0, 32'h13, 32'h0, 3'b000);
    check("lb_0x13", obs_rd[0], 32'hFFFFFF80);
    issue(1'b0, 1'b0, 32'h13, 32'h0, 3'b100);
    check("lbu_0x13", obs_rd[0], 32'h00000080);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 3'b010);
    check("lw_0x10_merged", obs_rd[0], 32'h80ADBEEF);

    // Illegal accesses
    wr_before = wr_cnt;
    issue(1'b0, 1'b0, 32'h11, 32'h0, 3'b001);
    check("lh_0x11_err", obs_err[0], 32'h1);
    check("lh_0x11_rdata", obs_rd[0], 32'h0);
    issue(1'b0, 1'b1, 32'h12, 32'hA5A5A5A5, 3'b010);
    check("sw_0x12_err", obs_err[0], 32'h1);
    issue(1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
    check("dbg_lw_0x100_err", obs_err[1], 32'h1);
    check("dbg_lw_0x100_rdata", obs_rd[1], 32'h0);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 3'b011);
    check("funct3_11_err", obs_err[0], 32'h1);
    check("err_no_write", 32'(wr_cnt - wr_before), 32'h0);

    // Both requesters held for six grants
    gseq.delete();
    hold[0] = 1'b1;
    hold[1] = 1'b1;
    n = 0;
    while (gseq.size() < 6 && n < 40) begin
      cycle();
      n++;
    end
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    drain();
    core_cnt = 0;
    changes = 0;
    for (int i = 0; i < 6 && i < gseq.size(); i++) begin
      if (gseq[i] == 1'b0) core_cnt++;
      if (i > 0 && gseq[i] != gseq[i-1]) changes++;
    end
`ifdef DMEM_ARB_RR_EN
    check("arb_core_grants", 32'(core_cnt), 32'd3);
    check("arb_alternations", 32'(changes), 32'd5);
`else
    check("arb_core_grants", 32'(core_cnt), 32'd6);
    check("arb_alternations", 32'(changes), 32'd0);
`endif

    // Pending debug store while the core requests continuously
    gseq.delete();
    hold[0] = 1'b1;
    set_req(1'b1, 1'b1, 32'h20, 32'h55AA55AA, 3'b010);
    n = 0;
    while (p_req[1] && gseq.size() < 4 && n < 40) begin
      cycle();
      n++;
    end
    served = !p_req[1];
    dbg_idx = gseq.size();
    hold[0] = 1'b0;
    drain();
`ifdef DMEM_ARB_RR_EN
    check("rr_dbg_served", 32'(served && dbg_idx <= 2), 32'h1);
`else
    check("fixed_dbg_starved", 32'(served), 32'h0);
`endif
    issue(1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    check("dbg_lw_0x20", obs_rd[1], 32'h55AA55AA);

    // Reset during the ACCESS cycle of a store
    issue(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010);
    set_req(1'b0, 1'b1, 32'h30, 32'h12345678, 3'b010);
    wait_grant(1'b0);
    bus.core_req = 1'b0;
    bus.dbg_req  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_wr_en", 32'(bus.mem_wr_en), 32'h0);
    check("midrst_mem_addr", bus.mem_addr, 32'h0);
    check("midrst_mem_wr_data", bus.mem_wr_data, 32'h0);
    check("midrst_mem_funct3", 32'(bus.mem_funct3), 32'h2);
    check("midrst_core_rvalid", 32'(bus.core_rvalid), 32'h0);
    check("midrst_core_gnt", 32'(bus.core_gnt), 32'h0);
    @(posedge clk);
    #1;
    check("midrst_wr_en_edge", 32'(bus.mem_wr_en), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    issue(1'b0, 1'b0, 32'h30, 32'h0, 3'b010);
    check("midrst_lw_0x30", obs_rd[0], 32'hCAFEF00D);
    check("midrst_store_dropped", 32'(obs_rd[0] != 32'h12345678), 32'h1);

    // Random traffic
    rnd_on = 1'b1;
    repeat (500) cycle();
    rnd_on = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
